// File: rtl/ycr1_imem_wb_resp.sv
// ycr1_imem_wb_resp
//
// Instruction-memory responder. Accepts core IMEM requests into a small FIFO and
// turns each read into a Wishbone classic single read cycle. Responses are
// returned strictly in acceptance order, one imem_resp pulse per request.
//
// Optional build macro: YCR1_IMEM_WB_RANGE_CHK_EN
//   defined   - requests with (imem_addr & RANGE_MASK) != RANGE_BASE answer RDY_ER
//               without touching the bus.
//   undefined - no address check; RANGE_BASE/RANGE_MASK are ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/_req_ack    core request handshake (ack = req & ~fifo_full)
//   imem_cmd, imem_addr  command (0 = read, 1 = write) and byte address
//   imem_rdata/_resp     response data and code (NOTRDY / RDY_OK / RDY_ER)
//   wbm_*                Wishbone classic master (read-only)

`ifndef YCR1_IMEM_AWIDTH
`define YCR1_IMEM_AWIDTH 32
`endif
`ifndef YCR1_IMEM_DWIDTH
`define YCR1_IMEM_DWIDTH 32
`endif

module ycr1_imem_wb_resp #(
  parameter int unsigned REQ_DEPTH   = 2,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] RANGE_BASE  = 32'h0000_0000,
  parameter logic [31:0] RANGE_MASK  = 32'hF000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_ack,
  input  logic                         imem_req,
  input  logic                         imem_cmd,
  input  logic [`YCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic [`YCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output logic [1:0]                   imem_resp,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic                         wbm_we_o,
  output logic [31:0]                  wbm_adr_o,
  output logic [3:0]                   wbm_sel_o,
  input  logic [31:0]                  wbm_dat_i,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i
);

  localparam int unsigned AW = `YCR1_IMEM_AWIDTH;
  localparam int unsigned DW = `YCR1_IMEM_DWIDTH;
  localparam int unsigned PW = $clog2(REQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  localparam logic       CMD_WR = 1'b1;
  localparam logic [1:0] NOTRDY = 2'b00;
  localparam logic [1:0] RDY_OK = 2'b01;
  localparam logic [1:0] RDY_ER = 2'b10;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // Request FIFO
  logic [AW-3:0] fifo_addr [REQ_DEPTH];
  logic          fifo_err  [REQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop, req_err;

  // Control
  logic [1:0]    state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [AW-3:0] adr_q, adr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          nxt_valid, nxt_err;
  logic [AW-3:0] nxt_addr;

  assign fifo_full    = (count_q == CW'(REQ_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign imem_req_ack = imem_req & ~fifo_full;
  assign push         = imem_req & imem_req_ack;
  assign pop          = (state_q == StResp);

`ifdef YCR1_IMEM_WB_RANGE_CHK_EN
  assign req_err = (imem_cmd == CMD_WR) | ((imem_addr & RANGE_MASK) != RANGE_BASE);
`else
  assign req_err = (imem_cmd == CMD_WR);
  logic unused_range;
  assign unused_range = ^{RANGE_BASE, RANGE_MASK, imem_addr[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REQ_DEPTH); i++) begin
        fifo_addr[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr_q] <= imem_addr[AW-1:2];
        fifo_err[wr_ptr_q]  <= req_err;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry to serve next: the head while idle, the one behind the head while the
  // head is being answered. If the FIFO holds nothing further, this cycle's push
  // is forwarded so a request into an empty FIFO starts without a bubble.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_err   = 1'b0;
    nxt_addr  = '0;
    if (state_q == StResp) begin
      if (count_q > CW'(1)) begin
        nxt_valid = 1'b1;
        nxt_err   = fifo_err[rd_ptr_q + PW'(1)];
        nxt_addr  = fifo_addr[rd_ptr_q + PW'(1)];
      end else if (push) begin
        nxt_valid = 1'b1;
        nxt_err   = req_err;
        nxt_addr  = imem_addr[AW-1:2];
      end
    end else begin
      if (!fifo_empty) begin
        nxt_valid = 1'b1;
        nxt_err   = fifo_err[rd_ptr_q];
        nxt_addr  = fifo_addr[rd_ptr_q];
      end else if (push) begin
        nxt_valid = 1'b1;
        nxt_err   = req_err;
        nxt_addr  = imem_addr[AW-1:2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StBus: begin
        // Error (slave or timeout) takes priority over a simultaneous ack.
        if (wbm_err_i || (cnt_q == TW'(TIMEOUT_CYC))) begin
          state_d    = StResp;
          cyc_d      = 1'b0;
          resp_err_d = 1'b1;
          rdata_d    = '0;
        end else if (wbm_ack_i) begin
          state_d    = StResp;
          cyc_d      = 1'b0;
          resp_err_d = 1'b0;
          rdata_d    = DW'(wbm_dat_i);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StIdle, StResp: begin
        state_d = StIdle;
        if (nxt_valid) begin
          if (nxt_err) begin
            // Rejected entries are answered without a bus cycle.
            state_d    = StResp;
            resp_err_d = 1'b1;
            rdata_d    = '0;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            adr_d   = nxt_addr;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_adr_o  = 32'({adr_q, 2'b00});
  assign wbm_sel_o  = {4{cyc_q}};
  assign imem_rdata = rdata_q;
  assign imem_resp  = (state_q != StResp) ? NOTRDY : (resp_err_q ? RDY_ER : RDY_OK);

endmodule

// File: tb/tb_ycr1_imem_wb_resp.sv
// Directed testbench for ycr1_imem_wb_resp (REQ_DEPTH=2, TIMEOUT_CYC=15).
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_ycr1_imem_wb_resp;

  localparam logic [1:0] NOTRDY = 2'b00;
  localparam logic [1:0] RDY_OK = 2'b01;
  localparam logic [1:0] RDY_ER = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ack, imem_req, imem_cmd;
  logic [31:0] imem_addr, imem_rdata;
  logic [1:0]  imem_resp;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i;

  int n_cmp = 0;
  int n_bad = 0;

  ycr1_imem_wb_resp #(
    .REQ_DEPTH   (2),
    .TIMEOUT_CYC (15),
    .RANGE_BASE  (32'h0000_0000),
    .RANGE_MASK  (32'hF000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_ack (imem_req_ack),
    .imem_req     (imem_req),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i)
  );

  always #5 clk = ~clk;

  // Wishbone slave: answers after slv_wait wait states.
  // slv_mode 0 = ack, 1 = err, 2 = ack+err, 3 = never answers.
  int unsigned slv_wait = 0;
  int unsigned slv_mode = 0;
  int unsigned wcnt = 0;
  logic        slv_hit;
  assign slv_hit   = wbm_cyc_o & wbm_stb_o & (wcnt == slv_wait);
  assign wbm_ack_i = slv_hit & ((slv_mode == 0) || (slv_mode == 2));
  assign wbm_err_i = slv_hit & ((slv_mode == 1) || (slv_mode == 2));
  assign wbm_dat_i = (wbm_adr_o == 32'h100) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | wbm_adr_o);

  always @(posedge clk) begin
    wcnt <= (wbm_cyc_o && !(wbm_ack_i || wbm_err_i)) ? wcnt + 1 : 0;
  end

  // Rising edges of cyc, to prove that rejected requests never reach the bus.
  int   cyc_rises = 0;
  logic cyc_prev  = 1'b0;
  always @(negedge clk) begin
    if (wbm_cyc_o && !cyc_prev) cyc_rises <= cyc_rises + 1;
    cyc_prev <= wbm_cyc_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Present one request for a cycle (must be accepted), then leave the bench in
  // the following cycle with imem_req low.
  task automatic issue(input logic [31:0] addr, input logic cmd);
    nxt();
    imem_req  = 1'b1;
    imem_cmd  = cmd;
    imem_addr = addr;
    #1;
    check("issue_ack", 32'(imem_req_ack), 32'd1);
    nxt();
    imem_req = 1'b0;
    imem_cmd = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic exp_ack [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int   acc;
  int   rises0;

  initial begin
    rst_n     = 1'b0;
    imem_req  = 1'b0;
    imem_cmd  = 1'b0;
    imem_addr = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_resp", 32'(imem_resp), 32'(NOTRDY));
    check("rst_rdata", imem_rdata, 32'h0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_ack_noreq", 32'(imem_req_ack), 32'd0);

    // Single read, zero-wait slave: cyc in N+1, RDY_OK in N+2
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    #1;
    check("rst_ack_follows", 32'(imem_req_ack), 32'd1);
    nxt();
    imem_req = 1'b0;
    #1;
    check("rd_cyc", 32'(wbm_cyc_o), 32'd1);
    check("rd_stb", 32'(wbm_stb_o), 32'd1);
    check("rd_adr", wbm_adr_o, 32'h100);
    check("rd_sel", 32'(wbm_sel_o), 32'hF);
    check("rd_we", 32'(wbm_we_o), 32'd0);
    check("rd_resp_early", 32'(imem_resp), 32'(NOTRDY));
    nxt(); #1;
    check("rd_resp", 32'(imem_resp), 32'(RDY_OK));
    check("rd_rdata", imem_rdata, 32'hDEAD_BEEF);
    check("rd_cyc_end", 32'(wbm_cyc_o), 32'd0);
    check("rd_sel_end", 32'(wbm_sel_o), 32'd0);
    nxt(); #1;
    check("rd_resp_once", 32'(imem_resp), 32'(NOTRDY));
    check("rd_rdata_hold", imem_rdata, 32'hDEAD_BEEF);

    // Write command: RDY_ER next cycle, no bus cycle
    rises0 = cyc_rises;
    issue(32'h200, 1'b1);
    check("wr_resp", 32'(imem_resp), 32'(RDY_ER));
    check("wr_rdata", imem_rdata, 32'h0);
    check("wr_cyc", 32'(wbm_cyc_o), 32'd0);
    nxt(); #1;
    check("wr_resp_once", 32'(imem_resp), 32'(NOTRDY));
    check("wr_nocyc", 32'(cyc_rises - rises0), 32'd0);

    // Slave error
    slv_mode = 1;
    issue(32'h300, 1'b0);
    check("berr_cyc", 32'(wbm_cyc_o), 32'd1);
    nxt(); #1;
    check("berr_resp", 32'(imem_resp), 32'(RDY_ER));
    check("berr_rdata", imem_rdata, 32'h0);

    // Simultaneous ack and err: err wins
    slv_mode = 2;
    issue(32'h304, 1'b0);
    nxt(); #1;
    check("both_resp", 32'(imem_resp), 32'(RDY_ER));
    slv_mode = 0;

    // Back-to-back reads with 2 wait states and backpressure
    slv_wait = 2;
    acc = 0;
    for (int c = 0; c < 17; c++) begin
      nxt();
      imem_req  = (acc < 4);
      imem_addr = 32'(acc * 4);
      #1;
      if (c < 10) check($sformatf("bp_ack%0d", c), 32'(imem_req_ack), 32'(exp_ack[c]));
      if (imem_req && imem_req_ack) acc++;
      if ((c % 4) == 0 && c > 0) begin
        check($sformatf("bp_resp%0d", c), 32'(imem_resp), 32'(RDY_OK));
        check($sformatf("bp_data%0d", c), imem_rdata, 32'hC0DE_0000 | 32'(c - 4));
      end else begin
        check($sformatf("bp_idle%0d", c), 32'(imem_resp), 32'(NOTRDY));
      end
    end
    imem_req = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    slv_wait = 0;

    // Timeout: slave silent, RDY_ER 16 cycles after cyc rises
    slv_mode = 3;
    issue(32'h400, 1'b0);
    check("to_cyc", 32'(wbm_cyc_o), 32'd1);
    for (int k = 2; k <= 16; k++) begin
      nxt(); #1;
      check($sformatf("to_wait%0d", k), 32'(imem_resp), 32'(NOTRDY));
    end
    check("to_cyc_held", 32'(wbm_cyc_o), 32'd1);
    nxt(); #1;
    check("to_resp", 32'(imem_resp), 32'(RDY_ER));
    check("to_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("to_rdata", imem_rdata, 32'h0);
    nxt(); #1;
    check("to_cyc_low", 32'(wbm_cyc_o), 32'd0);
    slv_mode = 0;
    issue(32'h500, 1'b0);
    nxt(); #1;
    check("to_next_resp", 32'(imem_resp), 32'(RDY_OK));
    check("to_next_data", imem_rdata, 32'hC0DE_0500);

`ifdef YCR1_IMEM_WB_RANGE_CHK_EN
    // Out-of-window address is rejected without a bus cycle
    rises0 = cyc_rises;
    issue(32'h2000_0000, 1'b0);
    check("rng_resp", 32'(imem_resp), 32'(RDY_ER));
    nxt(); #1;
    check("rng_nocyc", 32'(cyc_rises - rises0), 32'd0);
    issue(32'h0000_0040, 1'b0);
    nxt(); #1;
    check("rng_ok_resp", 32'(imem_resp), 32'(RDY_OK));
    check("rng_ok_data", imem_rdata, 32'hC0DE_0040);
`endif

    // Reset while a read is on the bus and a second one is queued
    slv_wait = 5;
    nxt();
    imem_req  = 1'b1;
    imem_addr = 32'h600;
    #1;
    check("mr_ack0", 32'(imem_req_ack), 32'd1);
    nxt();
    imem_addr = 32'h604;
    #1;
    check("mr_ack1", 32'(imem_req_ack), 32'd1);
    nxt();
    imem_req = 1'b0;
    #1;
    check("mr_busy", 32'(wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("mr_stb_drop", 32'(wbm_stb_o), 32'd0);
    check("mr_resp", 32'(imem_resp), 32'(NOTRDY));
    nxt();
    nxt();
    rst_n = 1'b1;
    #1;
    check("mr_rdata", imem_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      check($sformatf("mr_quiet_resp%0d", k), 32'(imem_resp), 32'(NOTRDY));
      check($sformatf("mr_quiet_cyc%0d", k), 32'(wbm_cyc_o), 32'd0);
    end
    slv_wait = 0;
    issue(32'h700, 1'b0);
    check("mr_new_adr", wbm_adr_o, 32'h700);
    nxt(); #1;
    check("mr_new_resp", 32'(imem_resp), 32'(RDY_OK));
    check("mr_new_data", imem_rdata, 32'hC0DE_0700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
